// File: rtl/axi_read_arbiter.sv
// Two-master, one-slave AXI read-channel arbiter. One whole burst is granted at a time,
// with round-robin on ties, and R beats are routed back to the master that owns the burst.
module axi_read_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              io_m0_ar_valid,
  input  logic [ADDR_W-1:0] io_m0_ar_addr,
  input  logic [LEN_W-1:0]  io_m0_ar_len,
  input  logic [2:0]        io_m0_ar_size,
  output logic              io_m0_ar_ready,
  input  logic              io_m0_r_ready,
  output logic              io_m0_r_valid,
  output logic [63:0]       io_m0_r_data,
  output logic              io_m0_r_last,

  input  logic              io_m1_ar_valid,
  input  logic [ADDR_W-1:0] io_m1_ar_addr,
  input  logic [LEN_W-1:0]  io_m1_ar_len,
  input  logic [2:0]        io_m1_ar_size,
  output logic              io_m1_ar_ready,
  input  logic              io_m1_r_ready,
  output logic              io_m1_r_valid,
  output logic [63:0]       io_m1_r_data,
  output logic              io_m1_r_last,

  output logic              io_s_ar_valid,
  output logic [ADDR_W-1:0] io_s_ar_addr,
  output logic [LEN_W-1:0]  io_s_ar_len,
  output logic [2:0]        io_s_ar_size,
  output logic [1:0]        io_s_ar_burst,
  input  logic              io_s_ar_ready,
  input  logic              io_s_r_valid,
  input  logic [63:0]       io_s_r_data,
  input  logic              io_s_r_last,
  output logic              io_s_r_ready,

  output logic              io_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e              state_q;
  logic                owner_q;
  logic                prio_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [2:0]          size_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                err_q;

  logic                grant;
  logic                win;
  logic [ADDR_W-1:0]   win_addr;
  logic [LEN_W-1:0]    win_len;
  logic [2:0]          win_size;
  logic                in_data;
  logic                owner_r_ready;
  logic                beat;

  // Winner selection; prio_q holds the last master granted, so a tie goes to the other one.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (state_q == StIdle) begin
      unique case ({io_m1_ar_valid, io_m0_ar_valid})
        2'b01: begin
          grant = 1'b1;
          win   = 1'b0;
        end
        2'b10: begin
          grant = 1'b1;
          win   = 1'b1;
        end
        2'b11: begin
          grant = 1'b1;
          win   = ~prio_q;
        end
        default: begin
          grant = 1'b0;
          win   = 1'b0;
        end
      endcase
    end
  end

  assign win_addr = win ? io_m1_ar_addr : io_m0_ar_addr;
  assign win_len  = win ? io_m1_ar_len  : io_m0_ar_len;
  assign win_size = win ? io_m1_ar_size : io_m0_ar_size;

  assign io_m0_ar_ready = grant & ~win;
  assign io_m1_ar_ready = grant & win;

  assign io_s_ar_valid = (state_q == StAddr);
  assign io_s_ar_addr  = addr_q;
  assign io_s_ar_len   = len_q;
  assign io_s_ar_size  = size_q;
  assign io_s_ar_burst = 2'b01;

  // R routing is purely combinational so beats reach the owner with no added latency.
  assign in_data       = (state_q == StData);
  assign owner_r_ready = owner_q ? io_m1_r_ready : io_m0_r_ready;
  assign io_s_r_ready  = in_data & owner_r_ready;
  assign beat          = io_s_r_valid & io_s_r_ready;

  assign io_m0_r_valid = in_data & ~owner_q & io_s_r_valid;
  assign io_m0_r_data  = (in_data & ~owner_q) ? io_s_r_data : 64'h0;
  assign io_m0_r_last  = in_data & ~owner_q & io_s_r_last;
  assign io_m1_r_valid = in_data & owner_q & io_s_r_valid;
  assign io_m1_r_data  = (in_data & owner_q) ? io_s_r_data : 64'h0;
  assign io_m1_r_last  = in_data & owner_q & io_s_r_last;

  assign io_err = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      prio_q  <= 1'b1;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            addr_q  <= win_addr;
            len_q   <= win_len;
            size_q  <= win_size;
            owner_q <= win;
            prio_q  <= win;
            cnt_q   <= win_len;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (io_s_ar_ready) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (beat) begin
            if (io_s_r_last) begin
              err_q   <= (cnt_q != '0);
              state_q <= StIdle;
            end else if (cnt_q == '0) begin
              // Slave overran the requested length: end the burst and refuse further beats.
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: a cycle vector table, hand-written multi-cycle sequences
// and a randomized run scored against a transaction-level model of masters and slave.
module tb_axi_read_arbiter;

  localparam logic [63:0] M0A = 64'h8000_0000;
  localparam logic [63:0] M1A = 64'h8000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_m0_ar_valid, io_m1_ar_valid;
  logic [63:0] io_m0_ar_addr, io_m1_ar_addr;
  logic [7:0]  io_m0_ar_len, io_m1_ar_len;
  logic [2:0]  io_m0_ar_size, io_m1_ar_size;
  logic        io_m0_ar_ready, io_m1_ar_ready;
  logic        io_m0_r_ready, io_m1_r_ready;
  logic        io_m0_r_valid, io_m1_r_valid;
  logic [63:0] io_m0_r_data, io_m1_r_data;
  logic        io_m0_r_last, io_m1_r_last;
  logic        io_s_ar_valid;
  logic [63:0] io_s_ar_addr;
  logic [7:0]  io_s_ar_len;
  logic [2:0]  io_s_ar_size;
  logic [1:0]  io_s_ar_burst;
  logic        io_s_ar_ready;
  logic        io_s_r_valid;
  logic [63:0] io_s_r_data;
  logic        io_s_r_last;
  logic        io_s_r_ready;
  logic        io_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axi_read_arbiter #(.ADDR_W(64), .LEN_W(8)) dut (
    .clock(clock), .reset(reset),
    .io_m0_ar_valid(io_m0_ar_valid), .io_m0_ar_addr(io_m0_ar_addr),
    .io_m0_ar_len(io_m0_ar_len), .io_m0_ar_size(io_m0_ar_size),
    .io_m0_ar_ready(io_m0_ar_ready), .io_m0_r_ready(io_m0_r_ready),
    .io_m0_r_valid(io_m0_r_valid), .io_m0_r_data(io_m0_r_data), .io_m0_r_last(io_m0_r_last),
    .io_m1_ar_valid(io_m1_ar_valid), .io_m1_ar_addr(io_m1_ar_addr),
    .io_m1_ar_len(io_m1_ar_len), .io_m1_ar_size(io_m1_ar_size),
    .io_m1_ar_ready(io_m1_ar_ready), .io_m1_r_ready(io_m1_r_ready),
    .io_m1_r_valid(io_m1_r_valid), .io_m1_r_data(io_m1_r_data), .io_m1_r_last(io_m1_r_last),
    .io_s_ar_valid(io_s_ar_valid), .io_s_ar_addr(io_s_ar_addr), .io_s_ar_len(io_s_ar_len),
    .io_s_ar_size(io_s_ar_size), .io_s_ar_burst(io_s_ar_burst),
    .io_s_ar_ready(io_s_ar_ready), .io_s_r_valid(io_s_r_valid), .io_s_r_data(io_s_r_data),
    .io_s_r_last(io_s_r_last), .io_s_r_ready(io_s_r_ready), .io_err(io_err)
  );

  typedef struct {
    logic m0v, m1v, sar, srv, srl, m0rr, m1rr;
    logic [7:0] l0, l1;
    logic e_m0ar, e_m1ar, e_sarv, e_srr, e_m0rv, e_m1rv, e_err;
    logic [63:0] ea;
  } vec_t;

  typedef struct {
    logic        own;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_m0_ar_valid = 0; io_m0_ar_addr = M0A; io_m0_ar_len = 0; io_m0_ar_size = 3;
    io_m1_ar_valid = 0; io_m1_ar_addr = M1A; io_m1_ar_len = 0; io_m1_ar_size = 3;
    io_m0_r_ready = 0; io_m1_r_ready = 0;
    io_s_ar_ready = 0; io_s_r_valid = 0; io_s_r_data = 0; io_s_r_last = 0;
  endtask

  // in = {m0v,m1v,sar,srv,srl,m0rr,m1rr}; ex = {m0ar,m1ar,sarv,srr,m0rv,m1rv,err}
  function automatic vec_t mk(input logic [6:0] in, input logic [7:0] l0, input logic [7:0] l1,
                              input logic [6:0] ex, input logic [63:0] ea);
    vec_t v;
    {v.m0v, v.m1v, v.sar, v.srv, v.srl, v.m0rr, v.m1rr} = in;
    v.l0 = l0;
    v.l1 = l1;
    {v.e_m0ar, v.e_m1ar, v.e_sarv, v.e_srr, v.e_m0rv, v.e_m1rv, v.e_err} = ex;
    v.ea = ea;
    return v;
  endfunction

  initial begin
    bit          rr_pat [7] = '{1, 1, 0, 0, 0, 1, 1};
    int          beat;
    bit          pend [2];
    logic [63:0] raddr [2];
    logic [7:0]  rlen [2];
    logic [2:0]  rsize [2];
    bit          m_rr [2];
    bit          busy, ar_sent, last_grant, own, in_data, w, g;
    bit          s_vld;
    logic [63:0] s_dat;
    int          s_left, bursts;
    ar_t         exp_q [$];
    ar_t         a;

    // Tie, single-beat, held-off request, backpressure, over-length and under-length bursts.
    vecs[0]  = mk(7'b1100000, 0, 1, 7'b1000000, 0);
    vecs[1]  = mk(7'b1110000, 0, 1, 7'b0010000, M0A);
    vecs[2]  = mk(7'b1101110, 0, 1, 7'b0001100, 0);
    vecs[3]  = mk(7'b1100000, 0, 1, 7'b0100000, 0);
    vecs[4]  = mk(7'b1000000, 0, 1, 7'b0010000, M1A);
    vecs[5]  = mk(7'b1010000, 0, 1, 7'b0010000, M1A);
    vecs[6]  = mk(7'b1001001, 0, 1, 7'b0001010, 0);
    vecs[7]  = mk(7'b1001100, 0, 1, 7'b0000010, 0);
    vecs[8]  = mk(7'b1001101, 0, 1, 7'b0001010, 0);
    vecs[9]  = mk(7'b1000000, 1, 1, 7'b1000000, 0);
    vecs[10] = mk(7'b1010000, 1, 1, 7'b0010000, M0A);
    vecs[11] = mk(7'b0001110, 1, 1, 7'b0001100, 0);
    vecs[12] = mk(7'b0000000, 1, 1, 7'b0000001, 0);
    vecs[13] = mk(7'b0100000, 0, 0, 7'b0100000, 0);
    vecs[14] = mk(7'b0010000, 0, 0, 7'b0010000, M1A);
    vecs[15] = mk(7'b0001001, 0, 0, 7'b0001010, 0);
    vecs[16] = mk(7'b0001001, 0, 0, 7'b0000001, 0);
    vecs[17] = mk(7'b0000000, 0, 0, 7'b0000000, 0);

    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    #3;
    chk("reset m0_ar_ready", 64'(io_m0_ar_ready), 0);
    chk("reset m1_ar_ready", 64'(io_m1_ar_ready), 0);
    chk("reset s_ar_valid", 64'(io_s_ar_valid), 0);
    chk("reset s_ar_addr", io_s_ar_addr, 0);
    chk("reset s_ar_len", 64'(io_s_ar_len), 0);
    chk("reset s_r_ready", 64'(io_s_r_ready), 0);
    chk("reset err", 64'(io_err), 0);
    chk("reset s_ar_burst", 64'(io_s_ar_burst), 64'h1);
    next_cycle();

    foreach (vecs[i]) begin
      io_m0_ar_valid = vecs[i].m0v; io_m1_ar_valid = vecs[i].m1v;
      io_m0_ar_len = vecs[i].l0;    io_m1_ar_len = vecs[i].l1;
      io_s_ar_ready = vecs[i].sar;  io_s_r_valid = vecs[i].srv;
      io_s_r_last = vecs[i].srl;    io_s_r_data = 64'hDEAD_BEEF;
      io_m0_r_ready = vecs[i].m0rr; io_m1_r_ready = vecs[i].m1rr;
      #3;
      chk($sformatf("row%0d m0_ar_ready", i), 64'(io_m0_ar_ready), 64'(vecs[i].e_m0ar));
      chk($sformatf("row%0d m1_ar_ready", i), 64'(io_m1_ar_ready), 64'(vecs[i].e_m1ar));
      chk($sformatf("row%0d s_ar_valid", i), 64'(io_s_ar_valid), 64'(vecs[i].e_sarv));
      chk($sformatf("row%0d s_r_ready", i), 64'(io_s_r_ready), 64'(vecs[i].e_srr));
      chk($sformatf("row%0d m0_r_valid", i), 64'(io_m0_r_valid), 64'(vecs[i].e_m0rv));
      chk($sformatf("row%0d m1_r_valid", i), 64'(io_m1_r_valid), 64'(vecs[i].e_m1rv));
      chk($sformatf("row%0d err", i), 64'(io_err), 64'(vecs[i].e_err));
      chk($sformatf("row%0d m0_r_data", i), io_m0_r_data, vecs[i].e_m0rv ? 64'hDEAD_BEEF : 0);
      chk($sformatf("row%0d m1_r_data", i), io_m1_r_data, vecs[i].e_m1rv ? 64'hDEAD_BEEF : 0);
      chk($sformatf("row%0d m0_r_last", i), 64'(io_m0_r_last), 64'(vecs[i].e_m0rv & vecs[i].srl));
      chk($sformatf("row%0d m1_r_last", i), 64'(io_m1_r_last), 64'(vecs[i].e_m1rv & vecs[i].srl));
      if (vecs[i].e_sarv) begin
        chk($sformatf("row%0d s_ar_addr", i), io_s_ar_addr, vecs[i].ea);
        chk($sformatf("row%0d s_ar_size", i), 64'(io_s_ar_size), 64'h3);
      end
      next_cycle();
    end

    // Backpressure: m1 len 3 with a 3-cycle r_ready stall after its second beat.
    idle_inputs();
    io_m1_ar_valid = 1; io_m1_ar_len = 3; io_m1_ar_addr = 64'h8000_2000;
    #3;
    chk("bp grant m1", 64'(io_m1_ar_ready), 1);
    next_cycle();
    io_m1_ar_valid = 0; io_s_ar_ready = 1;
    #3;
    chk("bp s_ar_valid", 64'(io_s_ar_valid), 1);
    chk("bp s_ar_len", 64'(io_s_ar_len), 3);
    chk("bp s_ar_addr", io_s_ar_addr, 64'h8000_2000);
    next_cycle();
    io_s_ar_ready = 0;
    beat = 0;
    for (int c = 0; c < 7; c++) begin
      io_s_r_valid = 1;
      io_s_r_data = 64'h1000 + 64'(beat);
      io_s_r_last = (beat == 3);
      io_m1_r_ready = rr_pat[c];
      #3;
      chk($sformatf("bp c%0d s_r_ready", c), 64'(io_s_r_ready), 64'(rr_pat[c]));
      chk($sformatf("bp c%0d m1_r_valid", c), 64'(io_m1_r_valid), 1);
      chk($sformatf("bp c%0d m1_r_data", c), io_m1_r_data, 64'h1000 + 64'(beat));
      chk($sformatf("bp c%0d m1_r_last", c), 64'(io_m1_r_last), 64'(beat == 3));
      chk($sformatf("bp c%0d err", c), 64'(io_err), 0);
      if (rr_pat[c]) beat++;
      next_cycle();
    end
    idle_inputs();
    io_m0_ar_valid = 1;
    #3;
    chk("bp no err after last", 64'(io_err), 0);
    chk("bp grant next cycle", 64'(io_m0_ar_ready), 1);
    next_cycle();

    // Reset during DATA of an m0 burst, then a tie must go to m0 again.
    io_m0_ar_valid = 0; io_s_ar_ready = 1;
    #3;
    chk("rst s_ar_valid", 64'(io_s_ar_valid), 1);
    next_cycle();
    io_s_ar_ready = 0; io_s_r_valid = 1; io_s_r_data = 64'h55; reset = 1;
    #3;
    chk("rst pre m0_r_valid", 64'(io_m0_r_valid), 1);
    next_cycle();
    reset = 0; io_m0_r_ready = 1;
    #3;
    chk("rst post m0_r_valid", 64'(io_m0_r_valid), 0);
    chk("rst post m0_r_data", io_m0_r_data, 0);
    chk("rst post s_r_ready", 64'(io_s_r_ready), 0);
    chk("rst post s_ar_valid", 64'(io_s_ar_valid), 0);
    chk("rst post s_ar_addr", io_s_ar_addr, 0);
    chk("rst post err", 64'(io_err), 0);
    next_cycle();
    io_s_r_valid = 0; io_m0_ar_valid = 1; io_m1_ar_valid = 1;
    #3;
    chk("rst tie m0_ar_ready", 64'(io_m0_ar_ready), 1);
    chk("rst tie m1_ar_ready", 64'(io_m1_ar_ready), 0);
    next_cycle();

    // Randomized traffic against a transaction-level model.
    reset = 1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 0;
    pend = '{0, 0};
    busy = 0; ar_sent = 0; last_grant = 1; own = 0;
    s_vld = 0; s_dat = 0; s_left = 0; bursts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 3) == 0) begin
          pend[n] = 1;
          raddr[n] = {32'h0, $urandom};
          rlen[n] = 8'($urandom_range(0, 5));
          rsize[n] = 3'($urandom_range(0, 3));
        end
        m_rr[n] = ($urandom_range(0, 3) != 0);
      end
      if (s_left > 0 && !s_vld && $urandom_range(0, 2) != 0) begin
        s_vld = 1;
        s_dat = {$urandom, $urandom};
      end
      io_m0_ar_valid = pend[0]; io_m0_ar_addr = raddr[0];
      io_m0_ar_len = rlen[0];   io_m0_ar_size = rsize[0];
      io_m1_ar_valid = pend[1]; io_m1_ar_addr = raddr[1];
      io_m1_ar_len = rlen[1];   io_m1_ar_size = rsize[1];
      io_m0_r_ready = m_rr[0];  io_m1_r_ready = m_rr[1];
      io_s_ar_ready = 1'($urandom_range(0, 1));
      io_s_r_valid = s_vld; io_s_r_data = s_dat; io_s_r_last = s_vld && (s_left == 1);
      #3;
      g = !busy && (pend[0] || pend[1]);
      w = (pend[0] && pend[1]) ? ~last_grant : pend[1];
      in_data = busy && ar_sent;
      chk("rnd m0_ar_ready", 64'(io_m0_ar_ready), 64'(g && !w));
      chk("rnd m1_ar_ready", 64'(io_m1_ar_ready), 64'(g && w));
      chk("rnd s_ar_valid", 64'(io_s_ar_valid), 64'(busy && !ar_sent));
      chk("rnd s_r_ready", 64'(io_s_r_ready), 64'(in_data && m_rr[own]));
      chk("rnd m0_r_valid", 64'(io_m0_r_valid), 64'(in_data && !own && s_vld));
      chk("rnd m1_r_valid", 64'(io_m1_r_valid), 64'(in_data && own && s_vld));
      chk("rnd err", 64'(io_err), 0);
      if (in_data && s_vld) begin
        chk("rnd r_data", own ? io_m1_r_data : io_m0_r_data, s_dat);
        chk("rnd r_last", 64'(own ? io_m1_r_last : io_m0_r_last), 64'(s_left == 1));
        chk("rnd idle r_data", own ? io_m0_r_data : io_m1_r_data, 0);
      end
      if (g) begin
        a.own = w; a.addr = raddr[w]; a.len = rlen[w]; a.size = rsize[w];
        exp_q.push_back(a);
        pend[w] = 0; last_grant = w; own = w; busy = 1; ar_sent = 0;
      end else if (busy && !ar_sent && io_s_ar_ready && exp_q.size() > 0) begin
        a = exp_q.pop_front();
        chk("rnd s_ar_addr", io_s_ar_addr, a.addr);
        chk("rnd s_ar_len", 64'(io_s_ar_len), 64'(a.len));
        chk("rnd s_ar_size", 64'(io_s_ar_size), 64'(a.size));
        s_left = int'(a.len) + 1;
        ar_sent = 1;
      end else if (in_data && s_vld && m_rr[own]) begin
        s_vld = 0;
        s_left--;
        if (s_left == 0) begin
          busy = 0; ar_sent = 0; bursts++;
        end
      end
      next_cycle();
    end
    chk("rnd bursts completed >= 20", 64'(bursts >= 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
